census_window_gen: RTL and testbench

Streaming 3x3 census transform stage directly upstream of the per-disparity Hamming-distance units. It accepts one raster-order grey pixel per valid cycle from the left or right camera and buffers two image lines. For every interior pixel it emits the 8-bit census signature, with bit order matching the Hamming unit's neighbour inputs. One instance is used per camera; both run in lockstep.

---
 rtl/census_window_gen_pkg.sv | 23 ++
 rtl/census_linebuf.sv | 22 ++
 rtl/census_window_gen.sv | 145 ++++++++++++++
 tb/tb_census_window_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/census_window_gen_pkg.sv
// Shared defaults, census bit positions and FSM encoding for the census window stage.
package census_window_gen_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;

  // Census bit index per neighbour, matching the Hamming unit's neighbour inputs
  localparam int CEN_TL = 0;
  localparam int CEN_T  = 1;
  localparam int CEN_TR = 2;
  localparam int CEN_L  = 3;
  localparam int CEN_R  = 4;
  localparam int CEN_BL = 5;
  localparam int CEN_B  = 6;
  localparam int CEN_BR = 7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/census_linebuf.sv
// Two-line pixel store: asynchronous read, synchronous write, so a same-cycle
// access sees the old contents (read-before-write).
module census_linebuf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/census_window_gen.sv
// Streaming 3x3 census transform: raster pixels in, 8-bit signature per interior
// pixel out, one cycle after the pixel that completes the window.
module census_window_gen
  import census_window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid_i,
  input  logic [PIX_W-1:0]         pix_i,
  input  logic                     sof_i,
  output logic                     census_valid_o,
  output logic [7:0]               census_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     frame_done_o,
  output logic                     frame_abort_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic accept, restart, abort, emit, last_pix;

  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [PIX_W-1:0] lb_r1, lb_r2, ctr;
  logic [2*PIX_W-1:0] lb_rdata;
  logic [7:0] census_d;

  // Each entry holds {row-2, row-1}; writing {old row-1, pix} ages the column by one line
  census_linebuf #(.DEPTH(IMG_W), .WIDTH(2*PIX_W)) u_linebuf (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata ({lb_r1, pix_i}),
    .rdata (lb_rdata)
  );

  assign {lb_r2, lb_r1} = lb_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    restart = 1'b0;
    abort   = 1'b0;
    if (pix_valid_i) begin
      case (state_q)
        ST_IDLE: if (sof_i) begin
          accept  = 1'b1;
          restart = 1'b1;
        end
        ST_ACTIVE: begin
          accept  = 1'b1;
          restart = sof_i;
          abort   = sof_i;
        end
        default: ;
      endcase
    end

    cur_col = restart ? '0 : col_q;
    cur_row = restart ? '0 : row_q;
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    emit = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      state_d = ST_ACTIVE;
      if (last_pix) begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end else if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Window after this accept: shift left, new right column is {row-2, row-1, pix}
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb_r2;
    win_d[1][2] = lb_r1;
    win_d[2][2] = pix_i;

    ctr = win_d[1][1];
    census_d = '0;
    census_d[CEN_TL] = win_d[0][0] < ctr;
    census_d[CEN_T]  = win_d[0][1] < ctr;
    census_d[CEN_TR] = win_d[0][2] < ctr;
    census_d[CEN_L]  = win_d[1][0] < ctr;
    census_d[CEN_R]  = win_d[1][2] < ctr;
    census_d[CEN_BL] = win_d[2][0] < ctr;
    census_d[CEN_B]  = win_d[2][1] < ctr;
    census_d[CEN_BR] = win_d[2][2] < ctr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      census_valid_o <= 1'b0;
      census_o       <= '0;
      col_o          <= '0;
      row_o          <= '0;
      frame_done_o   <= 1'b0;
      frame_abort_o  <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      census_valid_o <= emit;
      frame_done_o   <= emit && last_pix;
      frame_abort_o  <= abort;
      if (accept) win_q <= win_d;
      if (emit) begin
        census_o <= census_d;
        col_o    <= cur_col - 1'b1;
        row_o    <= cur_row - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_census_window_gen.sv
// Scoreboard bench for census_window_gen on an 8x6 image with directed patterns.
module tb_census_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid_i = 1'b0;
  logic       sof_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic       census_valid_o;
  logic [7:0] census_o;
  logic [2:0] col_o, row_o;
  logic       frame_done_o, frame_abort_o;

  census_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid_i    (pix_valid_i),
    .pix_i          (pix_i),
    .sof_i          (sof_i),
    .census_valid_o (census_valid_o),
    .census_o       (census_o),
    .col_o          (col_o),
    .row_o          (row_o),
    .frame_done_o   (frame_done_o),
    .frame_abort_o  (frame_abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cen;
    int         row;
    int         col;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0, n_out = 0, n_exp = 0;
  logic bub_q = 1'b0, chk_bub = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Hand-derived pixel patterns: 0 flat 0x55, 1 col*10, 2 row*10, 3 bright dot at (2,3)
  function automatic logic [7:0] pixval(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'h55;
      1:       return 8'(c * 10);
      2:       return 8'(r * 10);
      default: return (r == 2 && c == 3) ? 8'hFF : 8'h10;
    endcase
  endfunction

  // Push expected outputs for interior centres whose raster index lies in [lo,hi]
  task automatic exp_rng(input int lo, input int hi, input logic [7:0] cen);
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        int idx;
        idx = r * W + c;
        if (idx >= lo && idx <= hi) begin
          sbq.push_back('{cen: cen, row: r, col: c, done: (r == H - 2 && c == W - 2)});
          n_exp++;
        end
      end
  endtask

  task automatic send(input bit v, input bit s, input logic [7:0] p);
    pix_valid_i = v;
    sof_i = s;
    pix_i = p;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int pat, input int first, input int last, input bit bub);
    for (int i = first; i <= last; i++) begin
      if (bub) begin
        int n;
        n = 0;
        while ($urandom_range(1) == 0 && n < 16) begin
          send(1'b0, 1'b0, 8'hAA);
          n++;
        end
      end
      send(1'b1, i == 0, pixval(pat, i / W, i % W));
    end
    pix_valid_i = 1'b0;
    sof_i = 1'b0;
  endtask

  always @(posedge clk) bub_q <= !pix_valid_i;

  always @(negedge clk) begin
    exp_t e;
    if (chk_bub && bub_q) chk("bubble_valid", census_valid_o, 0);
    if (census_valid_o) begin
      n_out++;
      if (sbq.size() == 0) chk("unexpected_census", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("census", census_o, e.cen);
        chk("coord_rc", {row_o, 1'b0, col_o}, {3'(e.row), 1'b0, 3'(e.col)});
        chk("frame_done", frame_done_o, e.done);
      end
    end
  end

  initial begin
    #3;
    chk("reset_outputs", {census_valid_o, census_o, col_o, row_o, frame_done_o, frame_abort_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    exp_rng(0, 99, 8'h00);
    send_pix(0, 0, W*H-1, 1'b0);
    exp_rng(0, 99, 8'h29);
    send_pix(1, 0, W*H-1, 1'b0);
    exp_rng(0, 99, 8'h07);
    send_pix(2, 0, W*H-1, 1'b0);

    chk_bub = 1'b1;
    exp_rng(0, 99, 8'h07);
    send_pix(2, 0, W*H-1, 1'b1);
    send(1'b0, 1'b0, 8'h00);
    send(1'b0, 1'b0, 8'h00);
    chk_bub = 1'b0;

    exp_rng(0, 2*W+2, 8'h00);
    exp_rng(2*W+3, 2*W+3, 8'hFF);
    exp_rng(2*W+4, 99, 8'h00);
    send_pix(3, 0, W*H-1, 1'b0);

    // Abort: ramp frame cut at (3,5), vertical ramp restarts there
    exp_rng(0, 2*W+3, 8'h29);
    send_pix(1, 0, 3*W+4, 1'b0);
    exp_rng(0, 99, 8'h07);
    send(1'b1, 1'b1, pixval(2, 0, 0));
    chk("abort_pulse", frame_abort_o, 1);
    send_pix(2, 1, 1, 1'b0);
    chk("abort_single", frame_abort_o, 0);
    send_pix(2, 2, W*H-1, 1'b0);
    send(1'b0, 1'b0, 8'h00);

    // Idle pixels without sof produce nothing
    for (int i = 0; i < 12; i++) send(1'b1, 1'b0, 8'h33);
    send(1'b0, 1'b0, 8'h00);
    send(1'b0, 1'b0, 8'h00);
    chk("idle_no_output", n_out, n_exp);

    // Reset in row 3, right as the (3,2) result is being presented
    exp_rng(0, W+6, 8'h07);
    send_pix(2, 0, 3*W+2, 1'b0);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {census_valid_o, census_o, col_o, row_o, frame_done_o, frame_abort_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 8'h44);
    exp_rng(0, 99, 8'h29);
    send_pix(1, 0, W*H-1, 1'b0);

    repeat (5) send(1'b0, 1'b0, 8'h00);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("output_count", n_out, n_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
